// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg
// Shared definitions for the ALU op sequencer: opcode encodings, the FSM
// state type, the default opcode width and small decode helpers.
// Opcodes 0-7 are legal; any code with a bit set above bit 2 is illegal.
package alu_seq_pkg;

  localparam int OPC_W = 4;

  localparam logic [2:0] OP_NOP  = 3'd0;
  localparam logic [2:0] OP_ADD  = 3'd1;
  localparam logic [2:0] OP_SUB  = 3'd2;
  localparam logic [2:0] OP_NEG  = 3'd3;
  localparam logic [2:0] OP_INC  = 3'd4;
  localparam logic [2:0] OP_BRZ  = 3'd5;
  localparam logic [2:0] OP_BRN  = 3'd6;
  localparam logic [2:0] OP_CLRF = 3'd7;

  typedef enum logic [2:0] {
    IDLE,
    DRIVE,
    CAPTURE,
    RESOLVE,
    FINISH
  } state_t;

  // True for the four opcodes that actually exercise the ALU datapath.
  function automatic logic is_alu_op(input logic [2:0] code);
    return (code == OP_ADD) || (code == OP_SUB) ||
           (code == OP_NEG) || (code == OP_INC);
  endfunction

  // One-hot control vector ordered {add, inc, neg, sub}; zero for non-ALU codes.
  function automatic logic [3:0] ctl_onehot(input logic [2:0] code);
    logic [3:0] ctl;
    ctl = 4'b0000;
    case (code)
      OP_ADD:  ctl = 4'b1000;
      OP_INC:  ctl = 4'b0100;
      OP_NEG:  ctl = 4'b0010;
      OP_SUB:  ctl = 4'b0001;
      default: ctl = 4'b0000;
    endcase
    return ctl;
  endfunction

endpackage

// File: rtl/alu_op_sequencer_if.sv
// alu_op_sequencer_if
// Bundles the opcode handshake, the ALU control/flag lines and the status
// outputs of the sequencer.
//   master : the sequencer side (drives op_ready, alu_*, flags, status)
//   slave  : the opcode source / ALU side (drives op_valid, opcode, alu_z, alu_n)
interface alu_op_sequencer_if #(
  parameter int OPC_W = alu_seq_pkg::OPC_W
);

  logic             op_valid;
  logic             op_ready;
  logic [OPC_W-1:0] opcode;
  logic             alu_add;
  logic             alu_inc;
  logic             alu_neg;
  logic             alu_sub;
  logic             alu_z;
  logic             alu_n;
  logic             flag_z;
  logic             flag_n;
  logic             branch_taken;
  logic             done;
  logic             err;
  logic [15:0]      op_count;

  modport master (
    input  op_valid, opcode, alu_z, alu_n,
    output op_ready, alu_add, alu_inc, alu_neg, alu_sub,
           flag_z, flag_n, branch_taken, done, err, op_count
  );

  modport slave (
    output op_valid, opcode, alu_z, alu_n,
    input  op_ready, alu_add, alu_inc, alu_neg, alu_sub,
           flag_z, flag_n, branch_taken, done, err, op_count
  );

endinterface

// File: rtl/alu_seq_flag_reg.sv
// alu_seq_flag_reg
// Latched Z/N flag pair for the ALU sequencer.
//   clk, rst_n      : clock and asynchronous active-low reset
//   i_capture       : load i_z/i_n at the end of this cycle
//   i_clear         : clear both flags at the end of this cycle (wins over capture)
//   i_z, i_n        : combinational ALU zero/negative flags
//   o_flag_z/o_flag_n : registered flags
module alu_seq_flag_reg (
  input  logic clk,
  input  logic rst_n,
  input  logic i_capture,
  input  logic i_clear,
  input  logic i_z,
  input  logic i_n,
  output logic o_flag_z,
  output logic o_flag_n
);

  logic r_flagZ;
  logic r_flagN;

  // Flags only move on an explicit capture or clear so that a branch issued
  // right after an ALU op observes exactly that op's result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_flagZ <= 1'b0;
      r_flagN <= 1'b0;
    end else if (i_clear) begin
      r_flagZ <= 1'b0;
      r_flagN <= 1'b0;
    end else if (i_capture) begin
      r_flagZ <= i_z;
      r_flagN <= i_n;
    end
  end

  assign o_flag_z = r_flagZ;
  assign o_flag_n = r_flagN;

endmodule

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer
// Multi-cycle control sequencer for the ripple-carry ALU. Accepts opcodes on
// a valid/ready handshake, drives one-hot ALU controls for SETTLE_CYCLES+1
// cycles, captures Z/N after the adder settles and resolves BRZ/BRN against
// the latched flags.
//   clk, rst_n : clock and asynchronous active-low reset
//   bus        : alu_op_sequencer_if.master (handshake, ALU controls, flags, status)
// Parameters: SETTLE_CYCLES (1..15), OPC_W (>= 4).
// Optional: define ALU_SEQ_PERF_CNT_EN to enable the completed-ALU-op counter
// on op_count; otherwise op_count is tied to zero.
module alu_op_sequencer #(
  parameter int SETTLE_CYCLES = 2,
  parameter int OPC_W = 4
) (
  input  logic clk,
  input  logic rst_n,
  alu_op_sequencer_if.master bus
);

  import alu_seq_pkg::*;

  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

  state_t     r_state;
  state_t     w_stateNext;
  logic [2:0] r_code;
  logic [2:0] w_codeNext;
  logic       r_illegal;
  logic       w_illegalNext;
  logic [3:0] r_ctl;
  logic [3:0] w_ctlNext;
  logic [3:0] r_settle;
  logic [3:0] w_settleNext;
  logic       r_taken;
  logic       w_takenNext;
  logic       r_err;
  logic       w_errNext;
  logic       w_flagCapture;
  logic       w_flagClear;
  logic       w_flagZ;
  logic       w_flagN;
  logic       w_inLegal;
  logic [2:0] w_inCode;

  assign w_inLegal = (bus.opcode[OPC_W-1:3] == '0);
  assign w_inCode  = bus.opcode[2:0];

  // State and datapath registers. The control lines are held in flops so
  // they are glitch-free and drop immediately when rst_n falls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_code    <= OP_NOP;
      r_illegal <= 1'b0;
      r_ctl     <= 4'b0000;
      r_settle  <= 4'd0;
      r_taken   <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_state   <= w_stateNext;
      r_code    <= w_codeNext;
      r_illegal <= w_illegalNext;
      r_ctl     <= w_ctlNext;
      r_settle  <= w_settleNext;
      r_taken   <= w_takenNext;
      r_err     <= w_errNext;
    end
  end

  // Next-state and next-register logic. taken/err default to zero so they
  // are set while leaving RESOLVE and fall again as FINISH ends.
  always_comb begin
    w_stateNext   = r_state;
    w_codeNext    = r_code;
    w_illegalNext = r_illegal;
    w_ctlNext     = r_ctl;
    w_settleNext  = r_settle;
    w_takenNext   = 1'b0;
    w_errNext     = 1'b0;
    w_flagCapture = 1'b0;
    w_flagClear   = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.op_valid) begin
          w_codeNext    = w_inCode;
          w_illegalNext = !w_inLegal;
          if (w_inLegal && is_alu_op(w_inCode)) begin
            w_ctlNext    = ctl_onehot(w_inCode);
            w_settleNext = SETTLE_LOAD;
            w_stateNext  = DRIVE;
          end else begin
            w_stateNext  = RESOLVE;
          end
        end
      end
      DRIVE: begin
        if (r_settle == 4'd0) begin
          w_stateNext = CAPTURE;
        end else begin
          w_settleNext = r_settle - 4'd1;
        end
      end
      CAPTURE: begin
        w_flagCapture = 1'b1;
        w_ctlNext     = 4'b0000;
        w_stateNext   = FINISH;
      end
      RESOLVE: begin
        if (r_illegal) begin
          w_errNext = 1'b1;
        end else begin
          case (r_code)
            OP_BRZ:  w_takenNext = w_flagZ;
            OP_BRN:  w_takenNext = w_flagN;
            OP_CLRF: w_flagClear = 1'b1;
            default: w_takenNext = 1'b0;
          endcase
        end
        w_stateNext = FINISH;
      end
      FINISH: begin
        w_stateNext = IDLE;
      end
      default: begin
        w_ctlNext   = 4'b0000;
        w_stateNext = IDLE;
      end
    endcase
  end

  alu_seq_flag_reg u_flagReg (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_capture (w_flagCapture),
    .i_clear   (w_flagClear),
    .i_z       (bus.alu_z),
    .i_n       (bus.alu_n),
    .o_flag_z  (w_flagZ),
    .o_flag_n  (w_flagN)
  );

  assign bus.op_ready     = (r_state == IDLE);
  assign bus.alu_add      = r_ctl[3];
  assign bus.alu_inc      = r_ctl[2];
  assign bus.alu_neg      = r_ctl[1];
  assign bus.alu_sub      = r_ctl[0];
  assign bus.flag_z       = w_flagZ;
  assign bus.flag_n       = w_flagN;
  assign bus.done         = (r_state == FINISH);
  assign bus.branch_taken = r_taken;
  assign bus.err          = r_err;

`ifdef ALU_SEQ_PERF_CNT_EN
  logic [15:0] r_opCount;

  // Completed-ALU-op counter; bumps once per FINISH of a legal ALU opcode
  // and wraps naturally at 16 bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_opCount <= 16'd0;
    end else if ((r_state == FINISH) && !r_illegal && is_alu_op(r_code)) begin
      r_opCount <= r_opCount + 16'd1;
    end
  end

  assign bus.op_count = r_opCount;
`else
  assign bus.op_count = 16'd0;
`endif

endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb_alu_op_sequencer
// Directed testbench for alu_op_sequencer with a small 32-bit ALU model
// producing Z/N from the one-hot controls. Define ALU_SEQ_PERF_CNT_EN to
// also exercise the op counter.
module tb_alu_op_sequencer;

  import alu_seq_pkg::*;

  logic        clk;
  logic        rst_n;
  logic [31:0] aVal;
  logic [31:0] bVal;
  logic        forceZ;
  logic        forceN;
  logic [31:0] aluOut;
  int          errors;
  int          checks;

  alu_op_sequencer_if #(.OPC_W(4)) bus ();

  alu_op_sequencer #(.SETTLE_CYCLES(2), .OPC_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Free-running 10-unit clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference ALU: the result follows whichever control line is high.
  always_comb begin
    aluOut = 32'd0;
    if (bus.alu_add) aluOut = aVal + bVal;
    else if (bus.alu_inc) aluOut = aVal + 32'd1;
    else if (bus.alu_neg) aluOut = 32'd0 - aVal;
    else if (bus.alu_sub) aluOut = aVal - bVal;
  end

  assign bus.alu_z = (aluOut == 32'd0) | forceZ;
  assign bus.alu_n = aluOut[31] | forceN;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one opcode and follow it to its done pulse, recording the cycle
  // (relative to the handshake) and which controls were seen on the way.
  task automatic run_op(input logic [3:0] code, output int doneAt, output int ctlHigh,
                        output logic [3:0] ctlSeen, output logic multiHot,
                        output logic taken, output logic errOut);
    int waitCnt;
    logic [3:0] ctl;
    waitCnt = 0;
    while (!bus.op_ready && waitCnt < 50) begin
      tick();
      waitCnt++;
    end
    checks++;
    if (waitCnt >= 50) begin
      errors++;
      $display("[TB] FAIL op_ready_timeout: got op_ready=%0b want 1", bus.op_ready);
    end
    bus.op_valid = 1'b1;
    bus.opcode   = code;
    tick();
    bus.op_valid = 1'b0;
    bus.opcode   = 4'd0;
    doneAt = -1; ctlHigh = 0; ctlSeen = 4'b0000; multiHot = 1'b0; taken = 1'b0; errOut = 1'b0;
    for (int k = 1; k <= 30 && doneAt < 0; k++) begin
      ctl = {bus.alu_add, bus.alu_inc, bus.alu_neg, bus.alu_sub};
      if (ctl != 4'b0000) ctlHigh++;
      ctlSeen = ctlSeen | ctl;
      if ($countones(ctl) > 1) multiHot = 1'b1;
      if (bus.done) begin
        doneAt = k;
        taken  = bus.branch_taken;
        errOut = bus.err;
      end else begin
        tick();
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    checks++; if (bus.op_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_op_ready: got %b want 1", bus.op_ready); end
    checks++; if ({bus.alu_add, bus.alu_inc, bus.alu_neg, bus.alu_sub} !== 4'b0000) begin errors++; $display("[TB] FAIL reset_ctl: got %b want 0000", {bus.alu_add, bus.alu_inc, bus.alu_neg, bus.alu_sub}); end
    checks++; if ({bus.flag_z, bus.flag_n} !== 2'b00) begin errors++; $display("[TB] FAIL reset_flags: got %b want 00", {bus.flag_z, bus.flag_n}); end
    checks++; if ({bus.done, bus.err, bus.branch_taken} !== 3'b000) begin errors++; $display("[TB] FAIL reset_status: got %b want 000", {bus.done, bus.err, bus.branch_taken}); end
    checks++; if (bus.op_count !== 16'd0) begin errors++; $display("[TB] FAIL reset_op_count: got %h want 0000", bus.op_count); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_sub_brz();
    int d; int h; logic [3:0] s; logic m; logic t; logic e;
    aVal = 32'd5; bVal = 32'd5;
    run_op({1'b0, OP_SUB}, d, h, s, m, t, e);
    checks++; if (d !== 4) begin errors++; $display("[TB] FAIL sub_done_at: got %0d want 4", d); end
    checks++; if (h !== 3) begin errors++; $display("[TB] FAIL sub_ctl_cycles: got %0d want 3", h); end
    checks++; if ({s, m} !== 5'b0001_0) begin errors++; $display("[TB] FAIL sub_ctl_lines: got %b/%b want 0001/0", s, m); end
    checks++; if ({bus.flag_z, bus.flag_n} !== 2'b10) begin errors++; $display("[TB] FAIL sub_flags: got %b want 10", {bus.flag_z, bus.flag_n}); end
    run_op({1'b0, OP_BRZ}, d, h, s, m, t, e);
    checks++; if (d !== 2) begin errors++; $display("[TB] FAIL brz_done_at: got %0d want 2", d); end
    checks++; if (t !== 1'b1) begin errors++; $display("[TB] FAIL brz_taken: got %b want 1", t); end
    checks++; if ({s, e} !== 5'b0000_0) begin errors++; $display("[TB] FAIL brz_ctl_err: got %b/%b want 0000/0", s, e); end
  endtask

  task automatic test_neg_branch();
    int d; int h; logic [3:0] s; logic m; logic t; logic e;
    aVal = 32'd3; bVal = 32'd0;
    run_op({1'b0, OP_NEG}, d, h, s, m, t, e);
    checks++; if ({s, m} !== 5'b0010_0) begin errors++; $display("[TB] FAIL neg_ctl_lines: got %b/%b want 0010/0", s, m); end
    checks++; if ({bus.flag_z, bus.flag_n} !== 2'b01) begin errors++; $display("[TB] FAIL neg_flags: got %b want 01", {bus.flag_z, bus.flag_n}); end
    run_op({1'b0, OP_BRZ}, d, h, s, m, t, e);
    checks++; if ({d == 2, t} !== 2'b10) begin errors++; $display("[TB] FAIL neg_brz: got done_at=%0d taken=%b want 2/0", d, t); end
    run_op({1'b0, OP_BRN}, d, h, s, m, t, e);
    checks++; if ({d == 2, t} !== 2'b11) begin errors++; $display("[TB] FAIL neg_brn: got done_at=%0d taken=%b want 2/1", d, t); end
  endtask

  task automatic test_clrf();
    int d; int h; logic [3:0] s; logic m; logic t; logic e;
    aVal = 32'd1; bVal = 32'd1;
    forceZ = 1'b1; forceN = 1'b1;
    run_op({1'b0, OP_ADD}, d, h, s, m, t, e);
    forceZ = 1'b0; forceN = 1'b0;
    checks++; if ({bus.flag_z, bus.flag_n} !== 2'b11) begin errors++; $display("[TB] FAIL clrf_setup_flags: got %b want 11", {bus.flag_z, bus.flag_n}); end
    run_op({1'b0, OP_CLRF}, d, h, s, m, t, e);
    checks++; if (d !== 2) begin errors++; $display("[TB] FAIL clrf_done_at: got %0d want 2", d); end
    checks++; if ({bus.flag_z, bus.flag_n} !== 2'b00) begin errors++; $display("[TB] FAIL clrf_flags: got %b want 00", {bus.flag_z, bus.flag_n}); end
    checks++; if ({s, t, e} !== 6'b0000_00) begin errors++; $display("[TB] FAIL clrf_ctl_status: got %b/%b/%b want 0000/0/0", s, t, e); end
  endtask

  task automatic test_illegal();
    int d; int h; logic [3:0] s; logic m; logic t; logic e;
    aVal = 32'd5; bVal = 32'd7;
    run_op({1'b0, OP_SUB}, d, h, s, m, t, e);
    checks++; if ({bus.flag_z, bus.flag_n} !== 2'b01) begin errors++; $display("[TB] FAIL illegal_setup_flags: got %b want 01", {bus.flag_z, bus.flag_n}); end
    run_op(4'hB, d, h, s, m, t, e);
    checks++; if ({d == 2, e} !== 2'b11) begin errors++; $display("[TB] FAIL illegal_err: got done_at=%0d err=%b want 2/1", d, e); end
    checks++; if ({bus.flag_z, bus.flag_n} !== 2'b01) begin errors++; $display("[TB] FAIL illegal_flags: got %b want 01", {bus.flag_z, bus.flag_n}); end
    checks++; if ({s, t} !== 5'b0000_0) begin errors++; $display("[TB] FAIL illegal_ctl: got %b/%b want 0000/0", s, t); end
    aVal = 32'd2; bVal = 32'd3;
    run_op({1'b0, OP_ADD}, d, h, s, m, t, e);
    checks++; if ({d == 4, s, e} !== 6'b1_1000_0) begin errors++; $display("[TB] FAIL add_after_illegal: got done_at=%0d ctl=%b err=%b want 4/1000/0", d, s, e); end
    checks++; if ({bus.flag_z, bus.flag_n} !== 2'b00) begin errors++; $display("[TB] FAIL add_flags: got %b want 00", {bus.flag_z, bus.flag_n}); end
  endtask

  task automatic test_inc_nop();
    int d; int h; logic [3:0] s; logic m; logic t; logic e;
    aVal = 32'hFFFF_FFFF; bVal = 32'd0;
    run_op({1'b0, OP_INC}, d, h, s, m, t, e);
    checks++; if ({d == 4, h == 3, s} !== 6'b11_0100) begin errors++; $display("[TB] FAIL inc_timing: got done_at=%0d cycles=%0d ctl=%b want 4/3/0100", d, h, s); end
    checks++; if ({bus.flag_z, bus.flag_n} !== 2'b10) begin errors++; $display("[TB] FAIL inc_flags: got %b want 10", {bus.flag_z, bus.flag_n}); end
    tick();
    bus.op_valid = 1'b0;
    bus.opcode   = {1'b0, OP_ADD};
    for (int i = 0; i < 3; i++) tick();
    checks++; if ({bus.op_ready, bus.done, bus.alu_add} !== 3'b100) begin errors++; $display("[TB] FAIL idle_hold: got ready/done/add=%b want 100", {bus.op_ready, bus.done, bus.alu_add}); end
    run_op({1'b0, OP_NOP}, d, h, s, m, t, e);
    checks++; if ({d == 2, s, t, e} !== 7'b1_0000_00) begin errors++; $display("[TB] FAIL nop: got done_at=%0d ctl=%b taken=%b err=%b want 2/0000/0/0", d, s, t, e); end
    checks++; if ({bus.flag_z, bus.flag_n} !== 2'b10) begin errors++; $display("[TB] FAIL nop_flags: got %b want 10", {bus.flag_z, bus.flag_n}); end
  endtask

  task automatic test_reset_mid_op();
    int d; int h; logic [3:0] s; logic m; logic t; logic e;
    aVal = 32'd1; bVal = 32'd1;
    tick();
    bus.op_valid = 1'b1;
    bus.opcode   = {1'b0, OP_ADD};
    tick();
    bus.op_valid = 1'b0;
    checks++; if (bus.alu_add !== 1'b1) begin errors++; $display("[TB] FAIL midrst_drive: got alu_add=%b want 1", bus.alu_add); end
    #1 rst_n = 1'b0;
    #1;
    checks++; if ({bus.alu_add, bus.flag_z, bus.flag_n, bus.done} !== 4'b0000) begin errors++; $display("[TB] FAIL midrst_outputs: got add/z/n/done=%b want 0000", {bus.alu_add, bus.flag_z, bus.flag_n, bus.done}); end
    checks++; if (bus.op_count !== 16'd0) begin errors++; $display("[TB] FAIL midrst_op_count: got %h want 0000", bus.op_count); end
    @(posedge clk);
    #1 rst_n = 1'b1;
    tick();
    checks++; if ({bus.op_ready, bus.done, bus.alu_add} !== 3'b100) begin errors++; $display("[TB] FAIL midrst_release: got ready/done/add=%b want 100", {bus.op_ready, bus.done, bus.alu_add}); end
    run_op({1'b0, OP_ADD}, d, h, s, m, t, e);
    checks++; if ({d == 4, s} !== 5'b1_1000) begin errors++; $display("[TB] FAIL midrst_next_add: got done_at=%0d ctl=%b want 4/1000", d, s); end
  endtask

  task automatic test_perf_count();
    int d; int h; logic [3:0] s; logic m; logic t; logic e;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    aVal = 32'd4; bVal = 32'd1;
    run_op({1'b0, OP_ADD}, d, h, s, m, t, e);
    run_op({1'b0, OP_SUB}, d, h, s, m, t, e);
    run_op({1'b0, OP_INC}, d, h, s, m, t, e);
    run_op({1'b0, OP_NOP}, d, h, s, m, t, e);
    run_op({1'b0, OP_BRZ}, d, h, s, m, t, e);
    tick();
`ifdef ALU_SEQ_PERF_CNT_EN
    checks++; if (bus.op_count !== 16'd3) begin errors++; $display("[TB] FAIL perf_count_3: got %0d want 3", bus.op_count); end
    force dut.r_opCount = 16'hFFFF;
    tick();
    release dut.r_opCount;
    tick();
    checks++; if (bus.op_count !== 16'hFFFF) begin errors++; $display("[TB] FAIL perf_preload: got %h want ffff", bus.op_count); end
    run_op({1'b0, OP_NEG}, d, h, s, m, t, e);
    tick();
    checks++; if (bus.op_count !== 16'h0000) begin errors++; $display("[TB] FAIL perf_wrap: got %h want 0000", bus.op_count); end
`else
    checks++; if (bus.op_count !== 16'd0) begin errors++; $display("[TB] FAIL perf_disabled: got %0d want 0", bus.op_count); end
`endif
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst_n = 1'b0;
    aVal = 32'd0;
    bVal = 32'd0;
    forceZ = 1'b0;
    forceN = 1'b0;
    bus.op_valid = 1'b0;
    bus.opcode = 4'd0;
    $display("[TB] starting alu_op_sequencer bench");
    test_reset();
    test_sub_brz();
    test_neg_branch();
    test_clrf();
    test_illegal();
    test_inc_nop();
    test_reset_mid_op();
    test_perf_count();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
Multi-cycle control sequencer on the driving side of the ALU's control/flag interface. It accepts opcodes over a valid/ready handshake and drives the ALU's one-hot control lines (add, inc, neg, sub). After the ripple adder settles, it captures the ALU's Z/N outputs into a flag register. It also resolves conditional branches (BRZ/BRN) against the latched flags for the datapath's PC logic.

Parameters:
SETTLE_CYCLES, 2, number of cycles controls are held before Z/N are sampled (ripple-adder settle budget); legal range 1..15.
OPC_W, 4, opcode width.

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
op_valid  input  1  opcode offered.
op_ready  output  1  sequencer can accept an opcode (high only in IDLE).
opcode  input  OPC_W  operation; sampled when op_valid && op_ready.
alu_add  output  1  ALU add control.
alu_inc  output  1  ALU inc control.
alu_neg  output  1  ALU neg control.
alu_sub  output  1  ALU sub control.
alu_z  input  1  ALU zero flag (combinational from ALU).
alu_n  input  1  ALU negative flag (combinational from ALU).
flag_z  output  1  latched zero flag.
flag_n  output  1  latched negative flag.
branch_taken  output  1  one-cycle pulse with done for a taken BRZ/BRN.
done  output  1  one-cycle completion pulse for every accepted opcode.
err  output  1  one-cycle pulse with done for an illegal opcode.
op_count  output  16  completed ALU-op counter (see Optional Feature).

Behaviour:
- Reset values: the FSM goes to IDLE and op_ready=1. All other outputs are 0: alu_*, flag_z, flag_n, branch_taken, done, err and op_count.
- Opcodes: 0 NOP, 1 ADD, 2 SUB, 3 NEG, 4 INC, 5 BRZ, 6 BRN, 7 CLRF. Codes 8-15 are illegal.
- FSM states: IDLE, DRIVE, CAPTURE, RESOLVE, FINISH.
- IDLE:
  - On handshake with an ALU op (1-4), latch the opcode and go to DRIVE.
  - On NOP, CLRF, BRZ, BRN or an illegal code, go to RESOLVE.
- DRIVE:
  - Exactly one alu_* line is high, matching the latched opcode. The others are 0.
  - A settle counter loads SETTLE_CYCLES-1 and counts down. At 0, go to CAPTURE.
- CAPTURE: the alu_* line stays high. Sample alu_z and alu_n into flag_z and flag_n at the end of this cycle, then go to FINISH.
- RESOLVE:
  - BRZ: set the taken bit to flag_z. BRN: set it to flag_n.
  - CLRF: clear both flags at the end of this cycle.
  - Illegal code: set the err bit.
  - NOP: no action.
  - Flags are unchanged for every code except CLRF. Go to FINISH.
- FINISH:
  - All alu_* lines are 0.
  - done=1; branch_taken and err are valid in this cycle only.
  - Return to IDLE.
- Latency, with the handshake in cycle T:
  - ALU op: done in cycle T+SETTLE_CYCLES+2. The controls are high for SETTLE_CYCLES+1 cycles.
  - Non-ALU op: done in cycle T+2.
- Back-to-back operation: op_ready is 0 from T+1 until the FINISH→IDLE transition. A new opcode can be accepted in the cycle after done.
- Outputs: alu_* lines are glitch-free (driven from registered state, never from opcode directly) and never more than one high.
- Flags are written only in CAPTURE or by CLRF. A branch issued immediately after an ALU op sees that op's flags.
- op_valid deasserted with op_ready high: no state change.
- Reset mid-operation: the FSM returns to IDLE immediately and the controls drop asynchronously. Flags clear, and no done is produced.

Optional Feature:
Macro ALU_SEQ_PERF_CNT_EN.
- Defined: op_count increments by 1 in each FINISH cycle that completes an ALU op (1-4). It wraps from 0xFFFF to 0x0000 and is cleared by reset only.
- Undefined: op_count is tied to 0 and no counter flops are inferred. The port list is identical in both builds.

Decomposition:
- Package alu_seq_pkg: opcode constants (OP_NOP..OP_CLRF), the state enum, and the width constant OPC_W.
- Sub-module alu_seq_flag_reg: the Z/N register with capture-enable and clear inputs, async active-low reset.
- Top level: FSM, settle counter, control decode and the optional counter.

Test Plan:
- Reset mid-op: assert rst_n=0 during DRIVE of ADD → alu_add, flags, done and op_count are 0 immediately. op_ready=1 after release.
- SUB with the bench ALU model giving a=5, b=5 (Z=1, N=0), SETTLE_CYCLES=2:
  - alu_sub is high for exactly 3 cycles and done arrives at T+4.
  - flag_z=1, flag_n=0.
  - A following BRZ gives branch_taken=1 together with done at T'+2.
- NEG of a=3 (out=0xFFFFFFFD, N=1, Z=0) → flag_n=1. Then BRZ → done with branch_taken=0. Then BRN → branch_taken=1.
- CLRF after flags Z=1, N=1 → both flags are 0 in the cycle done pulses. alu_* stay 0 throughout.
- Illegal opcode 0xB → err=1 and done=1 in the same cycle, flags unchanged, no alu_* activity. The next ADD is accepted normally.
- ALU_SEQ_PERF_CNT_EN defined: issue 3 ALU ops, 1 NOP and 1 BRZ → op_count=3. Preload the counter to 0xFFFF via 65535 ops (or force) and issue 1 more ALU op → op_count=0.
